// File: rtl/quadrature_step_decoder_if.sv
// quadrature_step_decoder_if: encoder inputs, enable and decoded step/dir/err outputs
interface quadrature_step_decoder_if;
    logic       en;
    logic       a_in;
    logic       b_in;
    logic       step;
    logic       dir;
    logic       err;
    logic [7:0] err_cnt;
    modport master (output en, a_in, b_in, input step, dir, err, err_cnt);
    modport slave (input en, a_in, b_in, output step, dir, err, err_cnt);
endinterface

// File: rtl/quadrature_step_decoder.sv
// quadrature_step_decoder: synchronised, glitch-filtered A/B decoder producing step/dir with illegal-transition counting
// Define QDEC_X1_EN for x1 decoding (step only on 00<->01); default is x4.
module quadrature_step_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 4,
    parameter int FILT_W      = 3
) (
    input logic clk,
    input logic reset,
    quadrature_step_decoder_if.slave bus
);
    localparam int IW = $clog2(SYNC_STAGES + 1);
    typedef enum logic {INIT, RUN} state_t;
    state_t state, state_nxt;
    logic [IW-1:0] init_cnt;
    logic [SYNC_STAGES-1:0] sync_a, sync_b;
    logic [1:0] s, f, prev, chg;
    logic [FILT_W-1:0] cnt [2];
    logic load, up, single, valid, step_d, err_d;

    assign s      = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};
    assign chg    = f ^ prev;
    assign single = ^chg;
    // Gray order 00->01->11->10: moving forward means old A differs from new B
    assign up     = prev[1] ^ f[0];
`ifdef QDEC_X1_EN
    assign valid  = single & ~prev[1] & ~f[1];
`else
    assign valid  = single;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= INIT;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step_d    = 1'b0;
        err_d     = 1'b0;
        if (state == INIT) begin
            load      = init_cnt == IW'(SYNC_STAGES);
            state_nxt = load ? RUN : INIT;
        end else begin
            step_d = bus.en & valid;
            err_d  = bus.en & (&chg);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a      <= '0;
            sync_b      <= '0;
            f           <= '0;
            prev        <= '0;
            cnt[0]      <= '0;
            cnt[1]      <= '0;
            init_cnt    <= '0;
            bus.step    <= 1'b0;
            bus.dir     <= 1'b1;
            bus.err     <= 1'b0;
            bus.err_cnt <= '0;
        end else begin
            sync_a   <= {sync_a[SYNC_STAGES-2:0], bus.a_in};
            sync_b   <= {sync_b[SYNC_STAGES-2:0], bus.b_in};
            init_cnt <= (state == INIT) ? init_cnt + 1'b1 : init_cnt;
            bus.step <= step_d;
            bus.err  <= err_d;
            if (step_d) bus.dir <= up;
            if (err_d && bus.err_cnt != 8'hFF) bus.err_cnt <= bus.err_cnt + 8'd1;
            if (load) begin
                f    <= s;
                prev <= s;
            end else if (state == RUN) begin
                prev <= f;
                // a channel only follows its input after FILT_CYCLES consecutive mismatches
                for (int i = 0; i < 2; i++) begin
                    if (s[i] == f[i]) begin
                        cnt[i] <= '0;
                    end else if (cnt[i] == FILT_W'(FILT_CYCLES - 1)) begin
                        f[i]   <= s[i];
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_quadrature_step_decoder.sv
// tb_quadrature_step_decoder: scoreboard bench; each input change queues its expected pulse, the monitor pops and compares
module tb_quadrature_step_decoder;
    localparam int LAT = 2 + 4;

    typedef struct {
        logic [1:0] kind;
        logic       dir;
        logic [7:0] cnt;
        int         cyc;
    } ev_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    ev_t q[$];
    logic [1:0] m_prev;
    logic m_dir;
    int m_cnt;

    quadrature_step_decoder_if bus ();
    quadrature_step_decoder #(.SYNC_STAGES(2), .FILT_CYCLES(4), .FILT_W(3)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int pos(input logic [1:0] v);
        return v == 2'b00 ? 0 : v == 2'b01 ? 1 : v == 2'b11 ? 2 : 3;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // called at a falling edge; the next rising edge is the first to sample the new level
    task automatic drive(input logic a, input logic b);
        logic [1:0] c, x;
        logic vs;
        c  = {a, b};
        x  = c ^ m_prev;
        vs = (x == 2'b01) || (x == 2'b10);
`ifdef QDEC_X1_EN
        vs = vs && !c[1] && !m_prev[1];
`endif
        if (bus.en && x == 2'b11) begin
            m_cnt = (m_cnt == 255) ? 255 : m_cnt + 1;
            q.push_back('{2'b01, m_dir, 8'(m_cnt), cyc + 1 + LAT});
        end else if (bus.en && vs) begin
            m_dir = pos(c) == (pos(m_prev) + 1) % 4;
            q.push_back('{2'b10, m_dir, 8'(m_cnt), cyc + 1 + LAT});
        end
        m_prev   = c;
        bus.a_in = a;
        bus.b_in = b;
    endtask

    task automatic do_reset(input logic a, input logic b);
        @(negedge clk);
        reset    = 1'b1;
        bus.a_in = a;
        bus.b_in = b;
        idle(4);
        reset  = 1'b0;
        m_prev = {a, b};
        m_dir  = 1'b1;
        m_cnt  = 0;
        idle(10);
        check("rst_step", bus.step, 1'b0);
        check("rst_err", bus.err, 1'b0);
        check("rst_dir", bus.dir, 1'b1);
        check("rst_err_cnt", bus.err_cnt, 0);
    endtask

    always @(negedge clk) begin
        if (!reset && (bus.step || bus.err)) begin
            if (q.size() == 0) begin
                check("spurious", {bus.step, bus.err}, 2'b00);
            end else begin
                ev_t e;
                e = q.pop_front();
                check("kind", {bus.step, bus.err}, e.kind);
                check("latency", cyc, e.cyc);
                check("dir", bus.dir, e.dir);
                check("err_cnt", bus.err_cnt, e.cnt);
            end
        end
    end

    initial begin
        bus.en   = 1'b1;
        bus.a_in = 1'b1;
        bus.b_in = 1'b1;
        do_reset(1'b1, 1'b1);
        idle(50);
        check("idle_pending", q.size(), 0);
        check("idle_dir", bus.dir, 1'b1);
        check("idle_err_cnt", bus.err_cnt, 0);

        do_reset(1'b0, 1'b0);
        drive(1'b0, 1'b1); idle(20);
        drive(1'b1, 1'b1); idle(20);
        drive(1'b1, 1'b0); idle(20);
        drive(1'b0, 1'b0); idle(20);
        check("fwd_pending", q.size(), 0);
        check("fwd_dir", bus.dir, 1'b1);

        drive(1'b1, 1'b0); idle(20);
        drive(1'b1, 1'b1); idle(20);
        drive(1'b0, 1'b1); idle(20);
        drive(1'b0, 1'b0); idle(20);
        check("rev_pending", q.size(), 0);
        check("rev_dir", bus.dir, 1'b0);

        drive(1'b0, 1'b1); idle(20);
        bus.a_in = 1'b1;
        idle(3);
        bus.a_in = 1'b0;
        idle(20);
        check("glitch3_pending", q.size(), 0);
        drive(1'b1, 1'b1);
        idle(4);
        drive(1'b0, 1'b1);
        idle(20);
        check("glitch4_pending", q.size(), 0);

        drive(1'b0, 1'b0); idle(20);
        for (int i = 0; i < 150; i++) begin
            drive(1'b1, 1'b1); idle(20);
            drive(1'b0, 1'b0); idle(20);
        end
        check("sat_pending", q.size(), 0);
        check("sat_err_cnt", bus.err_cnt, 255);
        do_reset(1'b0, 1'b0);

        bus.en = 1'b0;
        drive(1'b0, 1'b1); idle(20);
        drive(1'b1, 1'b1); idle(20);
        bus.en = 1'b1;
        idle(30);
        check("en_pending", q.size(), 0);
        drive(1'b1, 1'b0); idle(20);
        check("reen_pending", q.size(), 0);
        check("reen_dir", bus.dir, 1'b1);

        bus.a_in = 1'b0;
        idle(2);
        do_reset(1'b0, 1'b0);
        idle(30);
        check("midrst_pending", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
